fifo_wr_arb: RTL

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb.sv
// Write side of an async FIFO shared by two burst requesters. Round-robin
// arbitration in IDLE; a granted burst owns the write port until its last beat.
module fifo_wr_arb #(
  parameter int DSIZE = 8,
  parameter int ASIZE = 4
) (
  input  logic             wclk,
  input  logic             wrst,
  input  logic             req0_valid,
  input  logic [DSIZE-1:0] req0_data,
  input  logic             req0_last,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [DSIZE-1:0] req1_data,
  input  logic             req1_last,
  output logic             req1_ready,
  input  logic [ASIZE:0]   wq2_rptr,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic             wclken,
  output logic             wfull,
  output logic [ASIZE:0]   wptr,
  output logic             grant_id,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             last_winner_q, last_winner_d;
  logic             grant_id_q, grant_id_d;
  logic [ASIZE:0]   wbin_q, wbin_d;
  logic [ASIZE:0]   wptr_q, wptr_d;
  logic             wfull_q, wfull_d;

  logic             sel_vld;
  logic             sel_id;
  logic             sel_valid;
  logic             sel_last;
  logic [DSIZE-1:0] sel_data;
  logic             write_ok;
  logic [ASIZE:0]   full_ptr;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      state_q       <= IDLE;
      last_winner_q <= 1'b1;
      grant_id_q    <= 1'b0;
      wbin_q        <= '0;
      wptr_q        <= '0;
      wfull_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_winner_q <= last_winner_d;
      grant_id_q    <= grant_id_d;
      wbin_q        <= wbin_d;
      wptr_q        <= wptr_d;
      wfull_q       <= wfull_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output / selection logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path through
  // the case statement leaves it unassigned, which would infer a latch.
  always_comb begin
    sel_vld = 1'b0;
    sel_id  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && req1_valid) begin
          sel_vld = 1'b1;
          sel_id  = ~last_winner_q;
        end else if (req0_valid) begin
          sel_vld = 1'b1;
          sel_id  = 1'b0;
        end else if (req1_valid) begin
          sel_vld = 1'b1;
          sel_id  = 1'b1;
        end
      end
      LOCK0: begin
        sel_vld = 1'b1;
        sel_id  = 1'b0;
      end
      LOCK1: begin
        sel_vld = 1'b1;
        sel_id  = 1'b1;
      end
      default: begin
        sel_vld = 1'b0;
        sel_id  = 1'b0;
      end
    endcase

    sel_valid = sel_id ? req1_valid : req0_valid;
    sel_last  = sel_id ? req1_last  : req0_last;
    sel_data  = sel_id ? req1_data  : req0_data;

    // Ready is offered to the owner regardless of its valid; reset blocks it.
    write_ok   = sel_vld & ~wfull_q & ~wrst;
    req0_ready = write_ok & ~sel_id;
    req1_ready = write_ok &  sel_id;
    wclken     = write_ok & sel_valid;
    wdata      = sel_vld ? sel_data : '0;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    last_winner_d = last_winner_q;
    grant_id_d    = grant_id_q;
    if (wclken) begin
      unique case (state_q)
        IDLE: begin
          last_winner_d = sel_id;
          grant_id_d    = sel_id;
          if (!sel_last) state_d = sel_id ? LOCK1 : LOCK0;
        end
        LOCK0, LOCK1: begin
          if (sel_last) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Write pointer and full flag
  // ---------------------------------------------------------------------------
  // Full when the next write pointer equals the read pointer with its two
  // MSBs inverted: the writer is exactly one lap ahead in Gray space.
  always_comb begin
    wbin_d   = wbin_q + {{ASIZE{1'b0}}, wclken};
    wptr_d   = wbin_d ^ (wbin_d >> 1);
    full_ptr = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
    wfull_d  = (wptr_d == full_ptr);
  end

  assign waddr    = wbin_q[ASIZE-1:0];
  assign wfull    = wfull_q;
  assign wptr     = wptr_q;
  assign grant_id = grant_id_q;
  assign busy     = (state_q != IDLE);

  a_ready_onehot: assert property (@(posedge wclk) disable iff (wrst)
    !(req0_ready && req1_ready));
  a_no_write_full: assert property (@(posedge wclk) disable iff (wrst)
    wclken |-> !wfull);

endmodule
